mem_dma_initiator: RTL and testbench
====================================

// Module: mem_dma_initiator
// PURPOSE
//  Bus initiator on the core's single-port memory interface (wren/wmask/wdata/addr/rdata, rdata registered, valid one cycle after addr).
//  Copies, fills or verifies a block of 32-bit words without CPU involvement; used by benches and the boot path to preload or check RAM.
//  Sits beside the Pipeline as a second master; external arbitration is outside this block (its bus outputs are idle-safe when not busy).
// PARAMETERS
//  LEN_W    16  width of word-count and error-count registers
//  ADDR_W   32  byte-address width of mem_addr; pointers step by 4, wrap modulo 2^ADDR_W
// PORTS
//  clk            in   1       rising-edge clock, single clock domain
//  rst            in   1       synchronous reset, active-high
//  start          in   1       1-cycle request; sampled only in IDLE
//  mode           in   2       2'b00 copy, 2'b01 fill, 2'b10 verify, 2'b11 reserved
//  src_addr       in   ADDR_W  source byte address (copy/verify), low 2 bits ignored
//  dst_addr       in   ADDR_W  destination byte address, low 2 bits ignored
//  len            in   LEN_W   number of words; 0 = empty job
//  pattern        in   32      fill word (fill mode)
//  abort          in   1       stop after current bus cycle
//  busy           out  1       job in progress
//  done           out  1       1-cycle pulse at job end (normal, empty, reserved or abort)
//  err_count      out  LEN_W   verify mismatches, saturating; cleared on accepted start
//  first_err_addr out  ADDR_W  dst address of first mismatch; 0 if none
//  mem_wren       out  1       write strobe
//  mem_wmask      out  4       byte mask, always 4'hF when mem_wren=1, else 4'h0
//  mem_wdata      out  32      write data
//  mem_addr       out  ADDR_W  word-aligned byte address ({ptr[ADDR_W-1:2],2'b00})
//  mem_rdata      in   32      read data, for addr presented previous cycle
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, mem_wren=0, mem_wmask=0, mem_wdata=0, mem_addr=0, err_count=0, first_err_addr=0.
//  Bus outputs registered? No: decoded from state/pointer regs; mem_wdata in copy = mem_rdata (combinational pass-through).
//  IDLE: start=1 latches src/dst/len/mode/pattern into regs, clears errs; len=0 or mode=11 -> DONE, else first op state.
//  Copy: C_RD (addr=src, wren=0) -> C_WR (addr=dst, wren=1, wdata=mem_rdata); 2 cycles/word.
//  Fill: F_WR (addr=dst, wren=1, wdata=pattern) each cycle; 1 cycle/word.
//  Verify: V_RS (addr=src) -> V_RD (addr=dst, capture mem_rdata into sbuf) -> V_CMP (compare mem_rdata vs sbuf, no bus op); 3 cycles/word.
//  After each word's last state: src+=4, dst+=4, remaining-=1; remaining==0 -> DONE, else back to first op state.
//  DONE: done=1 for exactly one cycle, busy=0 in DONE; next state IDLE. busy=1 in all other non-IDLE states.
//  Mismatch: err_count+=1 unless all-ones (saturate); first_err_addr set only when err_count was 0.
//  abort=1 in any op state: current state's bus cycle completes (a C_WR write still occurs), then DONE; a C_RD without its C_WR never writes.
//  start while busy: ignored. start and abort same cycle in IDLE: start wins, abort ignored.
//  rst mid-job: next edge all outputs to reset values; no further write issued.
//  Overlapping src/dst in copy: ascending order, no hazard handling (forward copy semantics).
//  Address wrap at 2^ADDR_W is silent.
// STRUCTURE
//  Shared include dma_defs.vh: mode codes (DMA_COPY/FILL/VERIFY/RSVD), state encodings, WORD_BYTES=4.
//  One sub-module: dma_word_counter (load len, decrement, zero flag) reused by future DMA channels.
//  Remainder (FSM, pointers, compare, error regs) in mem_dma_initiator.
// TESTING  (against the one-cycle-latency Memory model, 8192 words)
//  Copy: mem[0x100..0x103]=A0..A3, start mode=00 src=0x400 dst=0x800 len=4 -> mem[0x200..0x203]=A0..A3, done after 8 busy cycles.
//  Fill: mode=01 dst=0x1000 len=3 pattern=0xDEADBEEF -> 3 writes at 0x1000/4/8, done after 3 busy cycles, wmask=4'hF.
//  Verify: two equal 4-word blocks with word 2 changed -> err_count=1, first_err_addr=dst+8; identical -> err_count=0.
//  Empty/reserved: len=0 or mode=11 -> done pulse 1 cycle after start, no mem_wren ever asserted.
//  Abort: copy len=16, abort in 5th C_RD -> exactly 4 words written, done next cycle, start while busy had no effect.
//  Reset: rst asserted during C_WR -> next cycle mem_wren=0, busy=0; new job after reset runs normally.

Source files
------------

// File: rtl/mem_dma_initiator_pkg.sv
// rtl/mem_dma_initiator_pkg.sv - mode codes, FSM states and word size for the memory DMA initiator
package mem_dma_initiator_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      DMA_COPY   = 2'b00,
      DMA_FILL   = 2'b01,
      DMA_VERIFY = 2'b10,
      DMA_RSVD   = 2'b11
   } dma_mode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_C_RD,
      S_C_WR,
      S_F_WR,
      S_V_RS,
      S_V_RD,
      S_V_CMP,
      S_DONE
   } dma_state_e;

   function automatic dma_state_e first_op_state(input dma_mode_e m);
      case (m)
         DMA_COPY:   return S_C_RD;
         DMA_FILL:   return S_F_WR;
         DMA_VERIFY: return S_V_RS;
         default:    return S_DONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_dma_initiator_if.sv
// rtl/mem_dma_initiator_if.sv - single-port memory bus (registered rdata, one-cycle latency)
interface mem_dma_initiator_if #(
   parameter int ADDR_W = 32
);
   logic              mem_wren;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_wren, mem_wmask, mem_wdata, mem_addr,
      input  mem_rdata
   );

   modport slave (
      input  mem_wren, mem_wmask, mem_wdata, mem_addr,
      output mem_rdata
   );
endinterface

// File: rtl/dma_word_counter.sv
// rtl/dma_word_counter.sv - loadable down-counter with zero flag for DMA word counts
module dma_word_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec)
         count <= count - W'(1);
   end

   assign zero = (count == '0);
endmodule

// File: rtl/mem_dma_initiator.sv
// rtl/mem_dma_initiator.sv - block copy / fill / verify master on the core memory bus
module mem_dma_initiator
   import mem_dma_initiator_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [LEN_W-1:0]    len,
   input  logic [31:0]         pattern,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    err_count,
   output logic [ADDR_W-1:0]   first_err_addr,
   mem_dma_initiator_if.master bus
);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

   dma_state_e        state;
   dma_state_e        loop_state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [31:0]       pattern_q;
   logic [31:0]       sbuf;
   logic              load;
   logic              word_end;
   logic              last_word;

   assign load     = (state == S_IDLE) && start;
   assign word_end = state inside {S_C_WR, S_F_WR, S_V_CMP};

   // Loaded with len-1 so the zero flag marks the word currently in flight as the last one.
   dma_word_counter #(.W(LEN_W)) u_word_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (len - LEN_W'(1)),
      .dec      (word_end),
      .zero     (last_word)
   );

   always_comb begin
      loop_state = S_V_RS;
      case (state)
         S_C_WR:  loop_state = S_C_RD;
         S_F_WR:  loop_state = S_F_WR;
         default: loop_state = S_V_RS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         src_ptr        <= '0;
         dst_ptr        <= '0;
         pattern_q      <= '0;
         sbuf           <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         if (word_end) begin
            src_ptr <= src_ptr + STEP;
            dst_ptr <= dst_ptr + STEP;
            state   <= (last_word || abort) ? S_DONE : loop_state;
         end
         case (state)
            S_IDLE: if (start) begin
               src_ptr        <= src_addr & ALIGN_MASK;
               dst_ptr        <= dst_addr & ALIGN_MASK;
               pattern_q      <= pattern;
               err_count      <= '0;
               first_err_addr <= '0;
               state <= (len == '0) ? S_DONE : first_op_state(dma_mode_e'(mode));
            end
            S_C_RD: state <= abort ? S_DONE : S_C_WR;
            S_V_RS: state <= abort ? S_DONE : S_V_RD;
            S_V_RD: begin
               sbuf  <= bus.mem_rdata;
               state <= abort ? S_DONE : S_V_CMP;
            end
            S_V_CMP: if (bus.mem_rdata != sbuf) begin
               if (err_count != '1)
                  err_count <= err_count + LEN_W'(1);
               if (err_count == '0)
                  first_err_addr <= dst_ptr;
            end
            S_DONE: state <= S_IDLE;
            default: ;
         endcase
      end
   end

   assign busy = !(state inside {S_IDLE, S_DONE});
   assign done = (state == S_DONE);

   // Bus is idle (all zero) outside op states so an external arbiter can OR masters together.
   always_comb begin
      bus.mem_wren  = 1'b0;
      bus.mem_wmask = 4'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_addr  = '0;
      case (state)
         S_C_RD: bus.mem_addr = src_ptr;
         S_C_WR: begin
            bus.mem_addr  = dst_ptr;
            bus.mem_wren  = 1'b1;
            bus.mem_wmask = 4'hF;
            bus.mem_wdata = bus.mem_rdata;
         end
         S_F_WR: begin
            bus.mem_addr  = dst_ptr;
            bus.mem_wren  = 1'b1;
            bus.mem_wmask = 4'hF;
            bus.mem_wdata = pattern_q;
         end
         S_V_RS: bus.mem_addr = src_ptr;
         S_V_RD: bus.mem_addr = dst_ptr;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_dma_initiator.sv
// tb/tb_mem_dma_initiator.sv - scoreboard bench for mem_dma_initiator against a word-level reference model
module tb_mem_dma_initiator;
   import mem_dma_initiator_pkg::*;

   localparam int LEN_W     = 16;
   localparam int ADDR_W    = 32;
   localparam int MEM_WORDS = 8192;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic [31:0] pattern = '0;
   logic        busy;
   logic        done;
   logic [15:0] err_count;
   logic [31:0] first_err_addr;

   mem_dma_initiator_if #(.ADDR_W(ADDR_W)) bus ();

   mem_dma_initiator #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode           (mode),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .len            (len),
      .pattern        (pattern),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem   [MEM_WORDS];
   logic [31:0] model [MEM_WORDS];

   always @(posedge clk) begin
      if (bus.mem_wren)
         mem[bus.mem_addr[14:2]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[14:2]];
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int          cycles;
      logic [15:0] err;
      logic [31:0] first;
   } done_t;

   wr_t   exp_wr[$];
   done_t exp_done[$];
   int    busy_cnt = 0;
   int    n_compared = 0;
   int    n_mismatched = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_compared++;
      if (got !== want) begin
         n_mismatched++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      wr_t   w;
      done_t d;
      #1;
      if (rst) begin
         busy_cnt = 0;
         check("rst_wren", 64'(bus.mem_wren), 64'd0);
         check("rst_wmask", 64'(bus.mem_wmask), 64'd0);
         check("rst_addr", 64'(bus.mem_addr), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_done", 64'(done), 64'd0);
         check("rst_err_count", 64'(err_count), 64'd0);
         check("rst_first_err", 64'(first_err_addr), 64'd0);
      end else begin
         if (bus.mem_wren) begin
            if (exp_wr.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                        bus.mem_addr, bus.mem_wdata);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
               check("wr_data", 64'(bus.mem_wdata), 64'(w.data));
               check("wr_mask", 64'(bus.mem_wmask), 64'hF);
            end
         end else begin
            check("idle_wmask", 64'(bus.mem_wmask), 64'd0);
         end
         if (busy) busy_cnt++;
         if (done) begin
            if (exp_done.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("FAIL unexpected_done: done seen, none expected");
            end else begin
               d = exp_done.pop_front();
               check("busy_cycles", 64'(busy_cnt), 64'(d.cycles));
               check("err_count", 64'(err_count), 64'(d.err));
               check("first_err_addr", 64'(first_err_addr), 64'(d.first));
               check("busy_in_done", 64'(busy), 64'd0);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic set_word(input int i, input logic [31:0] v);
      mem[i] <= v;
      model[i] = v;
   endtask

   // Reference model works on whole words: cycles per word by mode, abort/reset cut after the
   // interrupted state's bus cycle, forward copy order, saturating mismatch count.
   task automatic run_job(input logic [1:0] m, input logic [31:0] sb, input logic [31:0] db,
                          input int n, input logic [31:0] pat, input int abort_cyc,
                          input int rst_cyc, input bit inject);
      int          cpw, total, stop_cyc, words, cut, sw, dw, errs, a, r;
      bit          inj;
      logic [31:0] first;
      wr_t         w;
      done_t       d;
      cpw   = (m == 2'b00) ? 2 : (m == 2'b01) ? 1 : 3;
      total = (n == 0 || m == 2'b11) ? 0 : n * cpw;
      a = (abort_cyc < total) ? abort_cyc : -1;
      r = (rst_cyc < total) ? rst_cyc : -1;
      cut = (r >= 0) ? r : a;
      words = (total == 0) ? 0 : n;
      stop_cyc = total;
      if (cut >= 0) begin
         words = cut / cpw + ((cut % cpw == cpw - 1) ? 1 : 0);
         stop_cyc = cut + 1;
      end
      inj = inject && total > 0 && r < 0;
      sw = int'(sb >> 2);
      dw = int'(db >> 2);
      errs = 0;
      first = '0;
      for (int i = 0; i < words; i++) begin
         case (m)
            2'b00: begin
               model[dw + i] = model[sw + i];
               w.addr = 32'((dw + i) * 4);
               w.data = model[dw + i];
               exp_wr.push_back(w);
            end
            2'b01: begin
               model[dw + i] = pat;
               w.addr = 32'((dw + i) * 4);
               w.data = pat;
               exp_wr.push_back(w);
            end
            default: if (model[sw + i] != model[dw + i]) begin
               if (errs == 0) first = 32'((dw + i) * 4);
               if (errs < 65535) errs++;
            end
         endcase
      end
      if (r < 0) begin
         d.cycles = stop_cyc;
         d.err    = 16'(errs);
         d.first  = first;
         exp_done.push_back(d);
      end

      @(negedge clk);
      mode = m; src_addr = sb; dst_addr = db; len = 16'(n); pattern = pat; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= stop_cyc; c++) begin
         start = inj && (c == 1);
         if (start) begin
            mode = 2'b01; dst_addr = 32'h0; len = 16'd5; pattern = ~pat;
         end
         abort = (c == a);
         rst   = (c == r);
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      for (int t = 0; t < 200 && (exp_wr.size() != 0 || exp_done.size() != 0); t++)
         @(negedge clk);
      if (exp_wr.size() != 0 || exp_done.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("FAIL job_timeout: %0d writes and %0d done pulses still outstanding",
                  exp_wr.size(), exp_done.size());
         exp_wr.delete();
         exp_done.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int          sw, dw, n, ab, bad;
      logic [1:0]  m;
      logic [31:0] v;
      for (int i = 0; i < MEM_WORDS; i++) begin
         v = $urandom;
         mem[i] <= v;
         model[i] = v;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) set_word(32'h100 + i, 32'hA0A0_0000 + 32'(i));
      run_job(2'b00, 32'h400, 32'h800, 4, 32'h0, -1, -1, 1'b1);
      run_job(2'b01, 32'h0, 32'h1000, 3, 32'hDEADBEEF, -1, -1, 1'b1);

      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         set_word(32'h300 + i, v);
         set_word(32'h340 + i, v);
      end
      run_job(2'b10, 32'hC00, 32'hD00, 4, 32'h0, -1, -1, 1'b0);
      set_word(32'h342, 32'h1234_5678);
      run_job(2'b10, 32'hC00, 32'hD00, 4, 32'h0, -1, -1, 1'b1);

      run_job(2'b00, 32'h400, 32'h800, 0, 32'h0, -1, -1, 1'b0);
      run_job(2'b11, 32'h400, 32'h800, 6, 32'h0, -1, -1, 1'b0);

      run_job(2'b00, 32'h4000, 32'h5000, 16, 32'h0, 8, -1, 1'b1);
      run_job(2'b00, 32'h2000, 32'h3000, 8, 32'h0, -1, 5, 1'b0);
      run_job(2'b00, 32'h2000, 32'h3000, 8, 32'h0, -1, -1, 1'b0);

      for (int j = 0; j < 24; j++) begin
         m  = 2'($urandom_range(0, 3));
         n  = $urandom_range(0, 12);
         sw = $urandom_range(0, MEM_WORDS - 16);
         dw = ($urandom_range(0, 3) == 0) ? sw + $urandom_range(1, 3)
                                          : $urandom_range(0, MEM_WORDS - 16);
         if (m == 2'b10 && $urandom_range(0, 1) == 1) begin
            for (int i = 0; i < n; i++) set_word(dw + i, model[sw + i]);
            if (n > 0 && $urandom_range(0, 1) == 1)
               set_word(dw + $urandom_range(0, n - 1), $urandom);
         end
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n * 3) : -1;
         run_job(m, 32'(sw * 4) + 32'($urandom_range(0, 3)), 32'(dw * 4) + 32'($urandom_range(0, 3)),
                 n, $urandom, ab, -1, 1'b1);
      end

      repeat (3) @(negedge clk);
      bad = 0;
      for (int i = 0; i < MEM_WORDS; i++)
         if (mem[i] !== model[i]) bad++;
      check("mem_image_bad_words", 64'(bad), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
